conv3x3_pipe: RTL and testbench
===============================

Name: conv3x3_pipe

Overview:
- Consumes the 3x3 window stream from the line-buffer image control stage.
- Multiplies each window by a programmable signed 3x3 kernel and sums the nine products.
- Rounds and saturates the sum, emitting one fixed-point pixel per valid window.
- Fully pipelined, no backpressure; feeds the activation/next-layer stage and flags end of each output line.

Parameters:
- INTEGER_BITS, 9, integer bits of pixel and coefficient (signed, two's complement)
- FIXED_POINT_BITS, 4, fractional bits of pixel and coefficient; W = INTEGER_BITS+FIXED_POINT_BITS
- LINE_WIDTH, 512, output pixels per line for o_line_done

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_pixel_data  in  9*W  window; element k = bits [k*W +: W], k=0..8, row=k/3, col=k%3
- i_pixel_data_valid  in  1  window valid
- i_coef_wr  in  1  coefficient write strobe
- i_coef_addr  in  4  coefficient index 0..8; 9..15 ignored
- i_coef_data  in  W  signed coefficient
- i_sat_clr  in  1  clear sticky saturation flag
- o_pixel  out  W  convolved pixel, signed
- o_pixel_valid  out  1  o_pixel valid
- o_line_done  out  1  one-cycle pulse on last pixel of a line
- o_sat  out  1  sticky: a saturated result has been output

Behaviour:
- Reset (i_rst, synchronous, active-high, clock i_clk): o_pixel=0, o_pixel_valid=0, o_line_done=0, o_sat=0, line counter=0, all pipeline valids=0. Coefficients reset to identity kernel: coef[4]=1<<FIXED_POINT_BITS, others 0.
- Coefficient write: on i_coef_wr with addr<=8, coef[addr] updated at clock edge. Windows accepted in the same cycle use the old value; from next cycle the new value applies. In-flight samples are unaffected.
- Pipeline, latency 4 cycles (valid at edge t -> o_pixel_valid at edge t+4), one window per cycle sustained, valid shifts with data:
  - S1: nine signed W x W products, 2W bits, 2*FIXED_POINT_BITS fractional bits.
  - S2: three row sums, 2W+2 bits.
  - S3: total sum, 2W+4 bits; no overflow possible.
  - S4: add 1<<(FIXED_POINT_BITS-1) (round half up toward +inf), arithmetic shift right by FIXED_POINT_BITS, saturate to signed W bits [-2^(W-1), 2^(W-1)-1], register into o_pixel.
- Non-valid stages hold data; o_pixel holds its last value when o_pixel_valid=0.
- Saturation: o_sat set when a valid S4 result is clipped. i_sat_clr clears it. Set and clear in the same cycle: set wins.
- Line counter counts o_pixel_valid cycles. o_line_done=1 coincident with the LINE_WIDTH-th valid output, then counter wraps to 0. Gaps in valid do not advance it.
- Reset mid-stream: in-flight samples discarded, no o_pixel_valid after reset, counter and coefficients return to reset values.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: S4 output negative after saturation is forced to 0 (ReLU); o_sat still reflects clipping before ReLU.
- Undefined: signed result passed unchanged. Latency 4 in both cases.

Test Plan:
- Reset, no coef writes; window element 4 = 0x0050 (5.0), others random; valid at cycle t -> o_pixel=0x0050, o_pixel_valid at t+4 only.
- Write all nine coefs 0x0010 (1.0); all window elements 0x0010 -> o_pixel=0x0090 (9.0), o_sat=0.
- Coef[4]=0x0008 (0.5), rest 0. Pixel 0x0001 -> 0x0001 (half-up). Pixel 0x1FFF (-1 LSB) -> 0x0000 (without CONV_RELU_EN).
- All coefs 0x0FFF, all pixels 0x0FFF -> o_pixel=0x0FFF, o_sat=1. All pixels 0x1000 -> 0x1000 (0x0000 with CONV_RELU_EN). i_sat_clr -> o_sat=0. i_sat_clr coincident with saturating output -> o_sat stays 1.
- 512 valid windows with random idle gaps -> o_line_done exactly once, on the 512th o_pixel_valid. Next 512 -> pulses again.
- Stream 3 windows, assert i_rst one cycle while in flight -> no o_pixel_valid afterwards. Next window returns the identity-kernel result.

Source files
------------

// File: rtl/conv3x3_pipe.sv
// rtl/conv3x3_pipe.sv - 3x3 signed fixed-point convolution, 4-stage pipeline.
// Optional ReLU on the output stage when CONV_RELU_EN is defined.
module conv3x3_pipe #(
  parameter int INTEGER_BITS     = 9,
  parameter int FIXED_POINT_BITS = 4,
  parameter int LINE_WIDTH       = 512
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic [9*(INTEGER_BITS+FIXED_POINT_BITS)-1:0] i_pixel_data,
  input  logic                                     i_pixel_data_valid,
  input  logic                                     i_coef_wr,
  input  logic [3:0]                               i_coef_addr,
  input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] i_coef_data,
  input  logic                                     i_sat_clr,
  output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] o_pixel,
  output logic                                     o_pixel_valid,
  output logic                                     o_line_done,
  output logic                                     o_sat
);

  localparam int W  = INTEGER_BITS + FIXED_POINT_BITS;
  localparam int PW = 2 * W;
  localparam int RW = 2 * W + 2;
  localparam int TW = 2 * W + 4;
  localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

  localparam logic signed [W-1:0]  COEF_ONE = W'(1 << FIXED_POINT_BITS);
  localparam logic signed [TW-1:0] ROUND_HALF = TW'(1 << (FIXED_POINT_BITS - 1));
  localparam logic signed [TW-1:0] MAXV = {{(TW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [TW-1:0] MINV = {{(TW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [CW-1:0]        LAST_COL = CW'(LINE_WIDTH - 1);

  logic signed [W-1:0]  coef [0:8];
  logic signed [W-1:0]  px   [0:8];
  logic signed [PW-1:0] prod [0:8];
  logic signed [RW-1:0] rows [0:2];
  logic signed [TW-1:0] total;
  logic                 v1, v2, v3;
  logic [CW-1:0]        col_cnt;

  always_comb begin
    for (int k = 0; k < 9; k++) px[k] = $signed(i_pixel_data[k*W +: W]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 9; k++) coef[k] <= (k == 4) ? COEF_ONE : '0;
    end else if (i_coef_wr && i_coef_addr <= 4'd8) begin
      coef[i_coef_addr] <= $signed(i_coef_data);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= i_pixel_data_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Datapath stages load only on valid so idle cycles hold the last sample.
  always_ff @(posedge i_clk) begin
    if (i_pixel_data_valid) begin
      for (int k = 0; k < 9; k++) prod[k] <= PW'(px[k]) * PW'(coef[k]);
    end
    if (v1) begin
      for (int r = 0; r < 3; r++)
        rows[r] <= RW'(prod[3*r]) + RW'(prod[3*r+1]) + RW'(prod[3*r+2]);
    end
    if (v2) begin
      total <= TW'(rows[0]) + TW'(rows[1]) + TW'(rows[2]);
    end
  end

  logic signed [TW-1:0] rounded, shifted;
  logic [W-1:0]         res;
  logic                 clip;

  always_comb begin
    rounded = total + ROUND_HALF;
    shifted = rounded >>> FIXED_POINT_BITS;
    clip    = 1'b0;
    if (shifted > MAXV) begin
      res  = {1'b0, {(W-1){1'b1}}};
      clip = 1'b1;
    end else if (shifted < MINV) begin
      res  = {1'b1, {(W-1){1'b0}}};
      clip = 1'b1;
    end else begin
      res = shifted[W-1:0];
    end
`ifdef CONV_RELU_EN
    if (res[W-1]) res = '0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
      o_line_done   <= 1'b0;
      o_sat         <= 1'b0;
      col_cnt       <= '0;
    end else begin
      o_pixel_valid <= v3;
      o_line_done   <= 1'b0;
      if (v3) begin
        o_pixel <= res;
        if (col_cnt == LAST_COL) begin
          col_cnt     <= '0;
          o_line_done <= 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      // A clip in the same cycle as a clear keeps the flag set.
      if (v3 && clip) o_sat <= 1'b1;
      else if (i_sat_clr) o_sat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv3x3_pipe.sv
// tb/tb_conv3x3_pipe.sv - scoreboard bench for conv3x3_pipe with a reference model.
module tb_conv3x3_pipe;
  localparam int W  = 13;
  localparam int LW = 512;

  logic           clk = 1'b0;
  logic           rst;
  logic [9*W-1:0] pixel_data;
  logic           pixel_data_valid;
  logic           coef_wr;
  logic [3:0]     coef_addr;
  logic [W-1:0]   coef_data;
  logic           sat_clr;
  logic [W-1:0]   pixel;
  logic           pixel_valid;
  logic           line_done;
  logic           sat;

  conv3x3_pipe dut (
    .i_clk(clk), .i_rst(rst),
    .i_pixel_data(pixel_data), .i_pixel_data_valid(pixel_data_valid),
    .i_coef_wr(coef_wr), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
    .i_sat_clr(sat_clr),
    .o_pixel(pixel), .o_pixel_valid(pixel_valid),
    .o_line_done(line_done), .o_sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pix;
    bit           ld;
    bit           clip;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mcoef[9];
  int   nout = 0;
  int   ld_seen = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Reference: exact integer dot product, round half up, clamp, optional ReLU.
  function automatic void expect_window(input logic [9*W-1:0] win);
    longint acc = 0;
    longint r;
    exp_t   e;
    logic [W-1:0] p;
    for (int k = 0; k < 9; k++) begin
      p = win[k*W +: W];
      acc += longint'($signed(p)) * longint'(mcoef[k]);
    end
    r = (acc + 8) >>> 4;
    e.clip = (r > 4095) || (r < -4096);
    if (r > 4095) r = 4095;
    if (r < -4096) r = -4096;
`ifdef CONV_RELU_EN
    if (r < 0) r = 0;
`endif
    e.pix = W'(r);
    e.ld  = (nout % LW) == (LW - 1);
    e.cyc = cyc + 4;
    nout++;
    sbq.push_back(e);
  endfunction

  task automatic step(input bit v, input logic [9*W-1:0] win, input bit wr,
                      input logic [3:0] addr, input logic [W-1:0] data, input bit clr);
    pixel_data_valid = v;
    pixel_data       = win;
    coef_wr          = wr;
    coef_addr        = addr;
    coef_data        = data;
    sat_clr          = clr;
    if (v) expect_window(win);
    if (wr && addr <= 4'd8) mcoef[addr] = int'($signed(data));
    @(posedge clk);
    #1;
    pixel_data_valid = 1'b0;
    coef_wr          = 1'b0;
    sat_clr          = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, pixel_data, 1'b0, 4'd0, '0, 1'b0);
  endtask

  task automatic write_coef(input int k, input logic [W-1:0] data);
    step(1'b0, pixel_data, 1'b1, 4'(k), data, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    pixel_data_valid = 1'b0;
    coef_wr = 1'b0;
    sat_clr = 1'b0;
    sbq.delete();
    nout = 0;
    for (int k = 0; k < 9; k++) mcoef[k] = (k == 4) ? 16 : 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sbq.size() > 0; i++) idle(1);
    chk(name, sbq.size(), 0);
  endtask

  function automatic logic [9*W-1:0] fill(input logic [W-1:0] v);
    logic [9*W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*W +: W] = v;
    return w;
  endfunction

  function automatic logic [9*W-1:0] rand_win();
    logic [9*W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*W +: W] = W'($urandom);
    return w;
  endfunction

  always @(negedge clk) begin
    if (pixel_valid) begin
      if (line_done) ld_seen++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid pixel=0x%0h at cycle %0d", pixel, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pixel", pixel, e.pix);
        chk("line_done", line_done, e.ld);
        chk("latency", cyc, e.cyc);
        if (e.clip) chk("sat_on_clip", sat, 1);
      end
    end
  end

  initial begin
    logic [9*W-1:0] w;
    pixel_data = '0;
    coef_addr = '0;
    coef_data = '0;
    do_reset(3);
    chk("rst_pixel", pixel, 0);
    chk("rst_valid", pixel_valid, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_sat", sat, 0);

    // Identity kernel after reset.
    for (int i = 0; i < 4; i++) begin
      w = rand_win();
      w[4*W +: W] = 13'h0050;
      step(1'b1, w, 1'b0, 4'd0, '0, 1'b0);
      if (i == 1) idle(2);
    end
    drain("drain_identity");
    chk("identity_const", pixel, 13'h0050);

    // All-ones kernel.
    for (int k = 0; k < 9; k++) write_coef(k, 13'h0010);
    step(1'b1, fill(13'h0010), 1'b0, 4'd0, '0, 1'b0);
    drain("drain_ones");
    chk("ones_const", pixel, 13'h0090);
    chk("ones_sat", sat, 0);

    // Rounding with a half-weight centre tap.
    for (int k = 0; k < 9; k++) write_coef(k, (k == 4) ? 13'h0008 : 13'h0000);
    w = '0;
    w[4*W +: W] = 13'h0001;
    step(1'b1, w, 1'b0, 4'd0, '0, 1'b0);
    w[4*W +: W] = 13'h1FFF;
    step(1'b1, w, 1'b0, 4'd0, '0, 1'b0);
    drain("drain_round");
    chk("round_neg_const", pixel, 13'h0000);

    // Saturation both directions, clear, and clear racing a new clip.
    for (int k = 0; k < 9; k++) write_coef(k, 13'h0FFF);
    step(1'b1, fill(13'h0FFF), 1'b0, 4'd0, '0, 1'b0);
    step(1'b1, fill(13'h1000), 1'b0, 4'd0, '0, 1'b0);
    drain("drain_sat");
    chk("sat_set", sat, 1);
    step(1'b0, pixel_data, 1'b0, 4'd0, '0, 1'b1);
    chk("sat_clr", sat, 0);
    step(1'b1, fill(13'h0FFF), 1'b0, 4'd0, '0, 1'b0);
    idle(2);
    step(1'b0, pixel_data, 1'b0, 4'd0, '0, 1'b1);
    drain("drain_sat_race");
    chk("sat_set_wins", sat, 1);

    // Random kernels and windows with gaps; covers two full lines.
    do_reset(1);
    ld_seen = 0;
    for (int k = 0; k < 9; k++) write_coef(k, W'($urandom_range(0, 127) - 64));
    for (int i = 0; i < 1100; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0)
        step(1'b1, rand_win(), 1'b1, 4'($urandom_range(0, 15)),
             W'($urandom_range(0, 127) - 64), 1'b0);
      else
        step(1'b1, rand_win(), 1'b0, 4'd0, '0, 1'b0);
    end
    drain("drain_random");
    chk("line_done_count", ld_seen, 2);

    // Reset while three windows are in flight.
    for (int k = 0; k < 9; k++) write_coef(k, 13'h0003);
    for (int i = 0; i < 3; i++) step(1'b1, rand_win(), 1'b0, 4'd0, '0, 1'b0);
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      chk("no_valid_after_rst", pixel_valid, 0);
      idle(1);
    end
    w = rand_win();
    w[4*W +: W] = 13'h0123;
    step(1'b1, w, 1'b0, 4'd0, '0, 1'b0);
    drain("drain_after_rst");
    chk("identity_after_rst", pixel, 13'h0123);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
